joy_dir_filter: RTL and testbench
=================================

Name: joy_dir_filter

Overview:
- Per-player joystick conditioner between the HPS/keyboard input merge and the core's active-low button ports.
- Replaces the fixed single-player last-pressed 4-way limiter with a parametrised, N-channel block.
- Each channel gets rotation/flip remap, per-bit debounce, a selectable direction-filter mode (last-pressed 4-way, first-held 4-way, 8-way with opposing-direction cancel) and optional autofire on the fire button.

Parameters:
- CHANNELS, 2: number of players; each channel is fully independent.
- DB_CYCLES, 16: debounce length in clk cycles; legal range 1..255.
- AF_HALF, 400000: autofire half-period in clk cycles; legal range ≥1. Counter width is $clog2(AF_HALF+1).

Ports:
- clk  in  1  system clock; same clock as the core.
- reset  in  1  synchronous, active-high reset.
- mode  in  2  filter mode: 0 = 4-way last-pressed, 1 = 4-way first-held, 2 = 8-way with cancel, 3 = reserved (behaves as 0).
- rotate  in  1  90° remap for horizontal orientation.
- flip  in  CHANNELS  per-channel 180° remap for the cocktail player.
- dir_in  in  4*CHANNELS  active-high raw directions; channel c occupies [4c+3:4c] as {up,down,left,right}.
- fire_in  in  CHANNELS  active-high raw fire.
- autofire_en  in  CHANNELS  per-channel autofire enable.
- dir_out  out  4*CHANNELS  filtered directions, same packing as dir_in.
- fire_out  out  CHANNELS  conditioned fire.

Behaviour:
- Reset: dir_out=0, fire_out=0. All sample registers, debounced states, debounce counters, masks and autofire counters cleared. Reset applied mid-operation has the same effect on the next edge.
- Remap is combinational on dir_in and uses port values, not debounced values.
  - rotate=1 maps {up,down,left,right} <- {left,right,down,up}.
  - flip[c]=1 then maps {up,down,left,right} <- {down,up,right,left}.
  - Order of application: rotate first, then flip.
- Sample stage: the remapped 4 bits plus fire_in are registered every cycle into s.
- Debounce, per bit, with debounced state q and counter n:
  - If s==q: n <= 0.
  - Else if n==DB_CYCLES-1: q <= s and n <= 0.
  - Else: n <= n+1.
  - An input held stable from cycle t changes q at edge t+1+DB_CYCLES.
  - Pulses shorter than DB_CYCLES cycles never reach q.
- Filter stage, per channel, on debounced d with new = d & ~d_prev (d_prev registered). Output is registered, so dir_out follows q by one cycle.
  - Mode 0 (last-pressed): if new≠0, mask <= one-hot of the highest-priority bit of new. Priority is up > down > left > right. dir_out <= d & mask.
  - Mode 1 (first-held): if (d & mask)==0, mask <= one-hot of the highest-priority bit of d, or 0 if d==0. dir_out <= d & mask_next. The held direction keeps ownership until it is released.
  - Mode 2 (8-way): dir_out <= d, except that up+down both set forces both to 0, and left+right both set forces both to 0.
- Mode change: on any cycle where mode differs from its registered copy, all masks <= 0 and dir_out <= 0 for that cycle. The new mode applies from the next cycle.
- Fire, with debounced fire f:
  - autofire_en[c]=0 or f=0: fire_out <= f, af counter <= 0, phase <= 1.
  - autofire_en[c]=1 and f=1: fire_out <= phase. The counter counts 0..AF_HALF-1; at AF_HALF-1 the phase toggles and the counter wraps to 0.
  - The first autofire output cycle is high, so timing matches the non-autofire case.
  - Dropping autofire_en mid-burst: next cycle fire_out=f.
- Latency, stable input to output: DB_CYCLES+2 cycles for both directions and fire.
- Channels never interact. Simultaneous events within one channel are resolved by the priority rule only.

Test Plan:
- Reset: drive all inputs high, assert reset 3 cycles → dir_out=0 and fire_out=0 during reset and on the first edge after it. Release reset with DB_CYCLES=4 → ch0 dir_out=4'b1000 (mode 0 keeps only up) at cycle 6 after release.
- Debounce: DB_CYCLES=4, a 3-cycle pulse on ch0 up → dir_out stays 0. A 4-cycle pulse → up asserted exactly at edge t+6 for 4 cycles.
- Mode 0: hold right, then press up 20 cycles later → dir_out=4'b1000. Release up while right is held → 4'b0000 until right is re-pressed. Press up and left on the same cycle → 4'b1000.
- Mode 1: hold right, then press up → 4'b0001 retained. Release right → 4'b1000 the cycle after d updates.
- Mode 2, SOCD and mode change: up+left → 4'b1010; up+down+left → 4'b0010. Switch mode 2→0 mid-hold → dir_out=0 for one cycle, then mode-0 rules apply.
- Remap and autofire: rotate=1 with left pressed → up out. flip[1]=1 with ch1 up → ch1 down out. AF_HALF=3, fire held with autofire_en → fire_out pattern 1,1,1,0,0,0,1… from the first output cycle. Release fire → 0 after DB_CYCLES+2 cycles.

Source files
------------

// File: rtl/joy_dir_filter.sv
// joy_dir_filter: per-player joystick conditioner (remap, debounce, 4/8-way filter, autofire)
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   mode[1:0]           0 last-pressed 4-way, 1 first-held 4-way, 2 8-way with cancel, 3 as 0
//   rotate, flip[c]     90 degree remap for all channels, 180 degree remap per channel
//   dir_in[4c+3:4c]     raw {up,down,left,right}; fire_in[c] raw fire; autofire_en[c]
//   dir_out, fire_out   conditioned outputs, same packing as the inputs
module joy_dir_filter #(
  parameter int CHANNELS  = 2,
  parameter int DB_CYCLES = 16,
  parameter int AF_HALF   = 400000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              mode,
  input  logic                    rotate,
  input  logic [CHANNELS-1:0]     flip,
  input  logic [4*CHANNELS-1:0]   dir_in,
  input  logic [CHANNELS-1:0]     fire_in,
  input  logic [CHANNELS-1:0]     autofire_en,
  output logic [4*CHANNELS-1:0]   dir_out,
  output logic [CHANNELS-1:0]     fire_out
);
  localparam int AW = $clog2(AF_HALF + 1);
  localparam logic [7:0] DB_LAST = 8'(DB_CYCLES - 1);
  localparam logic [AW-1:0] AF_LAST = AW'(AF_HALF - 1);
  logic [1:0] mode_r;
  logic mode_chg;
  assign mode_chg = mode != mode_r;
  always_ff @(posedge clk)
    if (reset) mode_r <= 2'd0;
    else mode_r <= mode;
  function automatic logic [3:0] pri(input logic [3:0] x);
    return x[3] ? 4'b1000 : x[2] ? 4'b0100 : x[1] ? 4'b0010 : x[0] ? 4'b0001 : 4'b0000;
  endfunction
  genvar c;
  for (c = 0; c < CHANNELS; c++) begin : g_ch
    logic [3:0] raw, rot, rmp, d, d_prev, nw, mask, mask_nx, socd, filt, out_r;
    logic [4:0] s, q;
    logic [7:0] n [5];
    logic [AW-1:0] af_cnt;
    logic phase, fo_r;
    assign raw = dir_in[4*c +: 4];
    assign rot = rotate ? {raw[1], raw[0], raw[2], raw[3]} : raw;
    assign rmp = flip[c] ? {rot[2], rot[3], rot[0], rot[1]} : rot;
    assign d = q[4:1];
    assign nw = d & ~d_prev;
    assign dir_out[4*c +: 4] = out_r;
    assign fire_out[c] = fo_r;
    // The output uses the updated mask so a new press shows up with no extra cycle.
    always_comb begin
      mask_nx = mode == 2'd1 ? (((d & mask) == 4'b0) ? pri(d) : mask) :
                mode == 2'd2 ? mask : ((nw != 4'b0) ? pri(nw) : mask);
      socd = {d[3:2] == 2'b11 ? 2'b00 : d[3:2], d[1:0] == 2'b11 ? 2'b00 : d[1:0]};
      filt = mode == 2'd2 ? socd : d & mask_nx;
    end
    always_ff @(posedge clk)
      if (reset) begin
        s <= '0;
        q <= '0;
        for (int b = 0; b < 5; b++) n[b] <= '0;
        d_prev <= '0;
        mask <= '0;
        out_r <= '0;
        fo_r <= 1'b0;
        af_cnt <= '0;
        phase <= 1'b1;
      end else begin
        s <= {rmp, fire_in[c]};
        for (int b = 0; b < 5; b++)
          if (s[b] == q[b]) n[b] <= '0;
          else if (n[b] == DB_LAST) begin
            q[b] <= s[b];
            n[b] <= '0;
          end else n[b] <= n[b] + 8'd1;
        d_prev <= d;
        mask <= mode_chg ? 4'b0 : mask_nx;
        out_r <= mode_chg ? 4'b0 : filt;
        // Phase idles high so the first autofire cycle matches plain fire timing.
        if (!autofire_en[c] || !q[0]) begin
          fo_r <= q[0];
          af_cnt <= '0;
          phase <= 1'b1;
        end else begin
          fo_r <= phase;
          af_cnt <= af_cnt == AF_LAST ? '0 : af_cnt + 1'b1;
          if (af_cnt == AF_LAST) phase <= ~phase;
        end
      end
  end
endmodule

// File: tb/tb_joy_dir_filter.sv
// tb_joy_dir_filter: scoreboard bench for joy_dir_filter (2 channels, DB_CYCLES=4, AF_HALF=3)
module tb_joy_dir_filter;
  logic clk = 0, reset = 1, rotate = 0;
  logic [1:0] mode = 0, flip = 0, fire_in = 0, autofire_en = 0, fire_out;
  logic [7:0] dir_in = 0, dir_out;
  typedef struct {
    logic [7:0] dir;
    logic [7:0] dm;
    logic [1:0] fire;
    logic [1:0] fm;
    string name;
  } exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0;

  joy_dir_filter #(.CHANNELS(2), .DB_CYCLES(4), .AF_HALF(3)) dut (
    .clk(clk), .reset(reset), .mode(mode), .rotate(rotate), .flip(flip),
    .dir_in(dir_in), .fire_in(fire_in), .autofire_en(autofire_en),
    .dir_out(dir_out), .fire_out(fire_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic void plan(input logic [7:0] d, input logic [7:0] dm,
                               input logic [1:0] f, input logic [1:0] fm, input string nm);
    sb.push_back('{d, dm, f, fm, nm});
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    dir_in = 0;
    fire_in = 0;
    repeat (k) step();
  endtask

  task automatic test_reset();
    exp_t e;
    dir_in = 8'hFF;
    fire_in = 2'b11;
    reset = 1;
    for (int i = 0; i < 3; i++) plan(8'h00, 8'hFF, 2'b00, 2'b11, "reset_hold");
    for (int i = 0; i < 8; i++)
      plan(i >= 5 ? 8'h88 : 8'h00, 8'hFF, i >= 5 ? 2'b11 : 2'b00, 2'b11, "reset_release");
    for (int i = 0; i < 11; i++) begin
      reset = i < 3;
      step();
      e = sb.pop_front();
      checks++;
      if ((dir_out & e.dm) !== e.dir || (fire_out & e.fm) !== e.fire) begin
        errors++;
        $display("FAIL %s step %0d: dir_out=%b fire_out=%b expected dir=%b fire=%b",
                 e.name, i, dir_out & e.dm, fire_out & e.fm, e.dir, e.fire);
      end
    end
    for (int i = 0; i < 9; i++)
      plan(i >= 6 ? 8'h88 : 8'h00, 8'hFF, i >= 6 ? 2'b11 : 2'b00, 2'b11, "reset_mid");
    for (int i = 0; i < 9; i++) begin
      reset = i == 0;
      step();
      e = sb.pop_front();
      checks++;
      if ((dir_out & e.dm) !== e.dir || (fire_out & e.fm) !== e.fire) begin
        errors++;
        $display("FAIL %s step %0d: dir_out=%b fire_out=%b expected dir=%b fire=%b",
                 e.name, i, dir_out & e.dm, fire_out & e.fm, e.dir, e.fire);
      end
    end
    idle(10);
  endtask

  task automatic test_debounce();
    exp_t e;
    for (int i = 0; i < 15; i++) plan(8'h00, 8'hFF, 2'b00, 2'b11, "db_short_pulse");
    for (int i = 0; i < 15; i++)
      plan((i >= 5 && i < 9) ? 8'h08 : 8'h00, 8'hFF, 2'b00, 2'b11, "db_exact_pulse");
    for (int i = 0; i < 30; i++) begin
      dir_in = (i < 3 || (i >= 15 && i < 19)) ? 8'h08 : 8'h00;
      step();
      e = sb.pop_front();
      checks++;
      if ((dir_out & e.dm) !== e.dir || (fire_out & e.fm) !== e.fire) begin
        errors++;
        $display("FAIL %s step %0d: dir_out=%b fire_out=%b expected dir=%b fire=%b",
                 e.name, i, dir_out & e.dm, fire_out & e.fm, e.dir, e.fire);
      end
    end
    idle(10);
  endtask

  task automatic test_mode0();
    exp_t e;
    logic up, lf, rt;
    mode = 0;
    idle(3);
    for (int i = 0; i < 100; i++)
      plan(i < 5 ? 8'h00 : i < 25 ? 8'h01 : i < 45 ? 8'h08 : i < 65 ? 8'h00 :
           i < 75 ? 8'h01 : i < 85 ? 8'h00 : i < 95 ? 8'h08 : 8'h00,
           8'hFF, 2'b00, 2'b11, "mode0_last_pressed");
    for (int i = 0; i < 100; i++) begin
      rt = i < 55 || (i >= 60 && i < 70);
      up = (i >= 20 && i < 40) || (i >= 80 && i < 90);
      lf = i >= 80 && i < 90;
      dir_in = {4'b0000, up, 1'b0, lf, rt};
      step();
      e = sb.pop_front();
      checks++;
      if ((dir_out & e.dm) !== e.dir || (fire_out & e.fm) !== e.fire) begin
        errors++;
        $display("FAIL %s step %0d: dir_out=%b fire_out=%b expected dir=%b fire=%b",
                 e.name, i, dir_out & e.dm, fire_out & e.fm, e.dir, e.fire);
      end
    end
    idle(10);
  endtask

  task automatic test_mode1();
    exp_t e;
    mode = 1;
    idle(3);
    for (int i = 0; i < 60; i++)
      plan(i < 5 ? 8'h00 : i < 35 ? 8'h01 : i < 50 ? 8'h08 : 8'h00,
           8'hFF, 2'b00, 2'b11, "mode1_first_held");
    for (int i = 0; i < 60; i++) begin
      dir_in = {4'b0000, i >= 10 && i < 45, 2'b00, i < 30};
      step();
      e = sb.pop_front();
      checks++;
      if ((dir_out & e.dm) !== e.dir || (fire_out & e.fm) !== e.fire) begin
        errors++;
        $display("FAIL %s step %0d: dir_out=%b fire_out=%b expected dir=%b fire=%b",
                 e.name, i, dir_out & e.dm, fire_out & e.fm, e.dir, e.fire);
      end
    end
    idle(10);
  endtask

  task automatic test_mode2();
    exp_t e;
    logic ul, dn;
    mode = 2;
    idle(3);
    for (int i = 0; i < 100; i++)
      plan(i < 5 ? 8'h00 : i < 25 ? 8'h0A : i < 45 ? 8'h02 : i < 55 ? 8'h00 :
           i < 70 ? 8'h0A : i < 85 ? 8'h00 : 8'h04,
           8'hFF, 2'b00, 2'b11, i == 70 ? "mode_change" : "mode2_socd");
    for (int i = 0; i < 100; i++) begin
      ul = i < 40 || (i >= 50 && i < 95);
      dn = (i >= 20 && i < 40) || (i >= 80 && i < 95);
      dir_in = {4'b0000, ul, dn, ul, 1'b0};
      mode = i >= 70 ? 2'd0 : 2'd2;
      step();
      e = sb.pop_front();
      checks++;
      if ((dir_out & e.dm) !== e.dir || (fire_out & e.fm) !== e.fire) begin
        errors++;
        $display("FAIL %s step %0d: dir_out=%b fire_out=%b expected dir=%b fire=%b",
                 e.name, i, dir_out & e.dm, fire_out & e.fm, e.dir, e.fire);
      end
    end
    idle(10);
  endtask

  task automatic test_remap();
    exp_t e;
    logic [7:0] din [3] = '{8'h82, 8'h88, 8'h81};
    logic [7:0] want [3] = '{8'h18, 8'h48, 8'h28};
    logic rot [3] = '{1'b1, 1'b0, 1'b1};
    logic [1:0] flp [3] = '{2'b00, 2'b10, 2'b11};
    for (int p = 0; p < 3; p++) begin
      rotate = rot[p];
      flip = flp[p];
      for (int i = 0; i < 12; i++) plan(i < 5 ? 8'h00 : want[p], 8'hFF, 2'b00, 2'b11, "remap");
      for (int i = 0; i < 12; i++) begin
        dir_in = din[p];
        step();
        e = sb.pop_front();
        checks++;
        if ((dir_out & e.dm) !== e.dir || (fire_out & e.fm) !== e.fire) begin
          errors++;
          $display("FAIL %s case %0d step %0d: dir_out=%b fire_out=%b expected dir=%b fire=%b",
                   e.name, p, i, dir_out & e.dm, fire_out & e.fm, e.dir, e.fire);
        end
      end
      idle(10);
    end
    rotate = 0;
    flip = 0;
  endtask

  task automatic test_autofire();
    exp_t e;
    logic a0, a1;
    autofire_en = 2'b01;
    for (int i = 0; i < 40; i++) begin
      a0 = i >= 5 && i < 31 && ((i - 5) / 3) % 2 == 0;
      a1 = i >= 5 && i < 31;
      plan(8'h00, 8'hFF, {a1, a0}, 2'b11, "autofire_burst");
    end
    for (int i = 0; i < 40; i++) begin
      fire_in = i < 26 ? 2'b11 : 2'b00;
      step();
      e = sb.pop_front();
      checks++;
      if ((dir_out & e.dm) !== e.dir || (fire_out & e.fm) !== e.fire) begin
        errors++;
        $display("FAIL %s step %0d: dir_out=%b fire_out=%b expected dir=%b fire=%b",
                 e.name, i, dir_out & e.dm, fire_out & e.fm, e.dir, e.fire);
      end
    end
    idle(10);
    for (int i = 0; i < 25; i++) begin
      a0 = i >= 14 || (i >= 5 && ((i - 5) / 3) % 2 == 0);
      plan(8'h00, 8'hFF, {1'b0, a0}, 2'b11, "autofire_drop_en");
    end
    for (int i = 0; i < 25; i++) begin
      fire_in = i < 20 ? 2'b01 : 2'b00;
      autofire_en = i < 14 ? 2'b01 : 2'b00;
      step();
      e = sb.pop_front();
      checks++;
      if ((dir_out & e.dm) !== e.dir || (fire_out & e.fm) !== e.fire) begin
        errors++;
        $display("FAIL %s step %0d: dir_out=%b fire_out=%b expected dir=%b fire=%b",
                 e.name, i, dir_out & e.dm, fire_out & e.fm, e.dir, e.fire);
      end
    end
    idle(10);
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_mode0();
    test_mode1();
    test_mode2();
    test_remap();
    test_autofire();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
